vblank_scheduler: RTL and testbench
===================================

Name: vblank_scheduler

Overview:
- Sequences per-frame game-logic updates (player move, flag pickup, fuel tick, spare slot) into the vertical-blanking window, one requester at a time.
- The granted requester owns the shared map-lookup port and game-state registers.
- Sits between the VGA timing generator (frame_start/blank_end pulses) and the update blocks. The top level muxes the map-lookup address by `owner`.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- TIMEOUT, 1023, maximum cycles a grant may stay open before it is revoked.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  asynchronous, active-low reset.
- game_active  in  1  high while the game FSM is in PLAY.
- frame_start  in  1  one-cycle pulse on the first cycle of vertical blanking.
- blank_end  in  1  one-cycle pulse a fixed margin before active video resumes.
- req  in  NUM_REQ  level request per requester.
- done  in  NUM_REQ  one-cycle completion pulse per requester.
- grant  out  NUM_REQ  one-hot or zero grant.
- owner  out  2  index of the current/last grant holder.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky: window ended or new frame arrived with work pending.
- slot_timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- frame_count  out  CNT_W  number of accepted frames.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, owner=0, pending=0, overrun=0, slot_timeout=0, frame_count=0, slot counter=0. All outputs are registered.
- States: IDLE, ARB, GRANT, GAP.
- IDLE:
  - On frame_start with game_active=1: pending<=req, frame_count+1 (wraps modulo 2^CNT_W), next state ARB.
  - frame_start with game_active=0 is ignored.
- ARB:
  - If pending==0: go to IDLE.
  - Otherwise: i = lowest set index; owner<=i; grant<=one-hot(i); slot counter<=0; next state GRANT.
- GRANT:
  - grant[i] is held high. The slot counter increments each cycle.
  - done[i]=1: clear pending[i], grant<=0, go to GAP.
  - Counter reaches TIMEOUT without done: clear pending[i], grant<=0, pulse slot_timeout, go to GAP.
  - done on a non-granted index is ignored.
- GAP: one idle cycle with grant=0, then ARB.
- Latency:
  - frame_start sampled at edge T gives ARB in cycle T+1 and grant high from T+2.
  - done high in cycle C gives grant low in C+1 and the next grant high in C+3.
- Requests are sampled only at frame_start. A req that rises afterwards waits for the next frame. Deasserting req after sampling does not cancel the slot.
- blank_end:
  - In GRANT: the current grant is never preempted and runs to done or timeout. After it ends, remaining pending bits are discarded, overrun<=1 if any were set, and state goes to IDLE.
  - In ARB/GAP with pending!=0: discard pending, overrun<=1, go to IDLE.
  - In IDLE: no effect.
- frame_start while busy: ignored (no re-sample, frame_count unchanged), overrun<=1.
- game_active falling in any state: next cycle grant=0, pending=0, state=IDLE. overrun is unchanged. An in-flight done is dropped.
- overrun clears only on reset.
- Simultaneous events:
  - done[i] and the timeout in the same cycle: treated as done, no slot_timeout.
  - done and blank_end in the same cycle: completion is recorded, then the blank_end rule is applied.
- owner holds its last value while grant=0.

Test Plan:
- Reset: hold rst=0 with random inputs → grant=0, busy=0, overrun=0, frame_count=0. Release; outputs are unchanged until frame_start.
- Priority ordering: game_active=1, req=4'b0101, frame_start at T; done[0] at T+4, done[2] at T+8.
  - grant=0001 during T+2..T+4 with owner=0; grant=0100 during T+7..T+8 with owner=2.
  - busy falls at T+11; frame_count=1.
- Watchdog: TIMEOUT=8, req=4'b0010, never pulse done → grant[1] high for 9 cycles, slot_timeout pulses once, then IDLE with overrun=0.
- Window overrun: req=4'b1111, blank_end while grant=0001 is open; done[0] two cycles later → no further grants, overrun=1, state IDLE.
- Abort: drop game_active during grant=0100 → grant=0 next cycle, busy=0, overrun unchanged. A new frame_start with game_active=1 restarts from the lowest index.
- Busy re-trigger: frame_start while in GRANT → overrun=1, frame_count is not incremented, the current sequence completes normally.

Source files
------------

// File: rtl/vblank_scheduler.sv
// Vertical-blanking update scheduler: samples per-frame requests at frame_start and grants the
// shared map-lookup port to one requester at a time, lowest index first, with a slot watchdog.
module vblank_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned OwnW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned SlotW  = $clog2(TIMEOUT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               game_active_i,
  input  logic               frame_start_i,
  input  logic               blank_end_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [OwnW-1:0]    owner_o,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               slot_timeout_o,
  output logic [CNT_W-1:0]   frame_count_o
);

  typedef enum logic [1:0] {StIdle, StArb, StGrant, StGap} state_e;

  localparam logic [SlotW-1:0]   TimeoutVal = SlotW'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] OneHot0    = NUM_REQ'(1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OwnW-1:0]    owner_q, owner_d;
  logic [SlotW-1:0]   slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               overrun_q, overrun_d;
  logic               slot_to_q, slot_to_d;
  logic               busy_q, busy_d;
  logic               win_closed_q, win_closed_d;

  function automatic logic [OwnW-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    logic [OwnW-1:0] idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = OwnW'(i);
    end
    return idx;
  endfunction

  logic               done_hit;
  logic               slot_end;
  logic [NUM_REQ-1:0] remaining;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    slot_cnt_d   = slot_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    slot_to_d    = 1'b0;
    win_closed_d = win_closed_q;
    done_hit     = |(done_i & grant_q);
    slot_end     = done_hit || (slot_cnt_q == TimeoutVal);
    remaining    = pending_q & ~grant_q;

    if (state_q != StIdle && !game_active_i) begin
      // Abort: leaving PLAY drops everything, including a done arriving this cycle.
      state_d      = StIdle;
      grant_d      = '0;
      pending_d    = '0;
      win_closed_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start_i && game_active_i) begin
            pending_d    = req_i;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            win_closed_d = 1'b0;
            state_d      = StArb;
          end
        end
        StArb: begin
          if (pending_q == '0) begin
            state_d = StIdle;
          end else if (blank_end_i) begin
            pending_d = '0;
            overrun_d = 1'b1;
            state_d   = StIdle;
          end else begin
            owner_d    = lowest_idx(pending_q);
            grant_d    = OneHot0 << lowest_idx(pending_q);
            slot_cnt_d = '0;
            state_d    = StGrant;
          end
        end
        StGrant: begin
          slot_cnt_d = slot_cnt_q + SlotW'(1);
          if (blank_end_i) win_closed_d = 1'b1;
          if (slot_end) begin
            grant_d   = '0;
            slot_to_d = !done_hit;
            // A window that closed during the slot ends the frame once the slot finishes.
            if (win_closed_q || blank_end_i) begin
              pending_d    = '0;
              overrun_d    = overrun_q | (|remaining);
              win_closed_d = 1'b0;
              state_d      = StIdle;
            end else begin
              pending_d = remaining;
              state_d   = StGap;
            end
          end
        end
        StGap: begin
          if (blank_end_i && pending_q != '0) begin
            pending_d = '0;
            overrun_d = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StArb;
          end
        end
        default: state_d = StIdle;
      endcase
      if (state_q != StIdle && frame_start_i) overrun_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      grant_q      <= '0;
      owner_q      <= '0;
      slot_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      slot_to_q    <= 1'b0;
      busy_q       <= 1'b0;
      win_closed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      slot_cnt_q   <= slot_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      slot_to_q    <= slot_to_d;
      busy_q       <= busy_d;
      win_closed_q <= win_closed_d;
    end
  end

  assign grant_o        = grant_q;
  assign owner_o        = owner_q;
  assign busy_o         = busy_q;
  assign overrun_o      = overrun_q;
  assign slot_timeout_o = slot_to_q;
  assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: priority order, watchdog, window overrun, abort, re-trigger.
module tb_vblank_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_active, frame_start, blank_end;
  logic [3:0]  req, done, grant;
  logic [1:0]  owner;
  logic        busy, overrun, slot_timeout;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  vblank_scheduler #(
    .NUM_REQ (4),
    .TIMEOUT (8),
    .CNT_W   (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .game_active_i  (game_active),
    .frame_start_i  (frame_start),
    .blank_end_i    (blank_end),
    .req_i          (req),
    .done_i         (done),
    .grant_o        (grant),
    .owner_o        (owner),
    .busy_o         (busy),
    .overrun_o      (overrun),
    .slot_timeout_o (slot_timeout),
    .frame_count_o  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input logic [3:0] r);
    req         = r;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] d);
    done = d;
    step();
    done = '0;
  endtask

  int n_grant, n_to;

  initial begin
    rst_n = 1'b0;
    {game_active, frame_start, blank_end} = 3'($urandom_range(0, 7));
    req  = 4'($urandom);
    done = 4'($urandom);
    repeat (4) begin
      step();
      {game_active, frame_start, blank_end} = 3'($urandom_range(0, 7));
      req  = 4'($urandom);
      done = 4'($urandom);
    end
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_fcount", 32'(frame_count), 32'h0);

    game_active = 1'b1; frame_start = 1'b0; blank_end = 1'b0; req = 4'b1111; done = '0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_fcount", 32'(frame_count), 32'h0);

    // Priority: req 0101, grant 0 then 2.
    pulse_frame(4'b0101);
    check("prio_arb_busy", 32'(busy), 32'h1);
    check("prio_arb_grant", 32'(grant), 32'h0);
    check("prio_fcount", 32'(frame_count), 32'h1);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("prio_g0", 32'(grant), 32'h1);
      check("prio_own0", 32'(owner), 32'h0);
    end
    pulse_done(4'b0001);
    check("prio_gap", 32'(grant), 32'h0);
    step();
    check("prio_arb2", 32'(grant), 32'h0);
    step();
    check("prio_g2a", 32'(grant), 32'h4);
    check("prio_own2", 32'(owner), 32'h2);
    step();
    check("prio_g2b", 32'(grant), 32'h4);
    pulse_done(4'b0100);
    check("prio_gap2", 32'(grant), 32'h0);
    check("prio_own_hold", 32'(owner), 32'h2);
    step();
    check("prio_busy_arb", 32'(busy), 32'h1);
    step();
    check("prio_busy_end", 32'(busy), 32'h0);
    check("prio_overrun", 32'(overrun), 32'h0);

    // Watchdog: TIMEOUT=8 keeps the grant for 9 cycles.
    pulse_frame(4'b0010);
    req = '0;
    step();
    n_grant = 0; n_to = 0;
    for (int i = 0; i < 20; i++) begin
      if (grant == 4'b0010) n_grant++;
      if (slot_timeout) begin
        n_to++;
        check("wd_to_grant_low", 32'(grant), 32'h0);
      end
      step();
    end
    check("wd_grant_cycles", 32'(n_grant), 32'd9);
    check("wd_timeout_pulses", 32'(n_to), 32'd1);
    check("wd_busy", 32'(busy), 32'h0);
    check("wd_overrun", 32'(overrun), 32'h0);
    check("wd_fcount", 32'(frame_count), 32'h2);

    // Abort during grant 0100; overrun stays 0.
    pulse_frame(4'b0101);
    step();
    check("ab_g0", 32'(grant), 32'h1);
    pulse_done(4'b0001);
    step();
    step();
    check("ab_g2", 32'(grant), 32'h4);
    game_active = 1'b0;
    step();
    check("ab_grant", 32'(grant), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_overrun", 32'(overrun), 32'h0);
    game_active = 1'b1;
    pulse_frame(4'b0101);
    step();
    check("ab_restart_g", 32'(grant), 32'h1);
    check("ab_restart_own", 32'(owner), 32'h0);
    check("ab_fcount", 32'(frame_count), 32'h4);
    pulse_done(4'b0001);
    step();
    step();
    check("ab_restart_g2", 32'(grant), 32'h4);
    pulse_done(4'b0100);
    step();
    step();
    check("ab_done_busy", 32'(busy), 32'h0);

    // Window overrun: blank_end while grant 0001 open, done two cycles later.
    pulse_frame(4'b1111);
    req = '0;
    step();
    check("win_g0", 32'(grant), 32'h1);
    blank_end = 1'b1;
    step();
    blank_end = 1'b0;
    check("win_not_preempted", 32'(grant), 32'h1);
    step();
    pulse_done(4'b0001);
    check("win_grant_off", 32'(grant), 32'h0);
    check("win_busy", 32'(busy), 32'h0);
    check("win_overrun", 32'(overrun), 32'h1);
    n_grant = 0;
    for (int i = 0; i < 6; i++) begin
      if (grant != 4'b0000) n_grant++;
      step();
    end
    check("win_no_more_grants", 32'(n_grant), 32'd0);

    // Busy re-trigger after a fresh reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pulse_frame(4'b0001);
    req = '0;
    step();
    check("rt_g0", 32'(grant), 32'h1);
    pulse_frame(4'b1111);
    req = '0;
    check("rt_overrun", 32'(overrun), 32'h1);
    check("rt_fcount", 32'(frame_count), 32'h1);
    check("rt_still_granted", 32'(grant), 32'h1);
    pulse_done(4'b0001);
    check("rt_gap", 32'(grant), 32'h0);
    step();
    step();
    check("rt_idle_busy", 32'(busy), 32'h0);
    check("rt_idle_grant", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
